// File: rtl/adc_spi_responder_if.sv
// adc_spi_responder_if: SPI pin bundle between an ADC master controller and
// the LTC2308-style responder model.
// Ports: adc_sclk (SPI clock, idle low), adc_cs_n (frame select, rise = CONVST),
//        adc_din (config bits, MSB first), adc_dout (result bits, MSB first).
interface adc_spi_responder_if;
  logic adc_sclk;
  logic adc_cs_n;
  logic adc_din;
  logic adc_dout;

  modport master (
    output adc_sclk,
    output adc_cs_n,
    output adc_din,
    input  adc_dout
  );

  modport slave (
    input  adc_sclk,
    input  adc_cs_n,
    input  adc_din,
    output adc_dout
  );
endinterface

// File: rtl/adc_spi_responder.sv
// adc_spi_responder: slave-side model of a 12-bit, 8-channel SPI ADC (LTC2308 style).
// Latency: DOUT bit valid SYNC_STAGES+1 clocks after cs_n fall / sclk fall;
//          result captured CONV_CYCLES clocks after the frame's cs_n rise.
// Backpressure: none; the master owns sclk/cs_n pacing, protocol abuse sets proto_err.
// Ports: clk_clk/reset_reset_n (clock, async active-low reset), spi (slave modport:
//        adc_sclk, adc_cs_n, adc_din in; adc_dout out), sample_data (analog source),
//        sample_ch (channel of last started conversion), conv_busy, frame_done (pulse),
//        proto_err (sticky), err_clr (synchronous clear, set wins).
module adc_spi_responder #(
  parameter int          CONV_CYCLES = 80,
  parameter int          SYNC_STAGES = 2,
  parameter logic [5:0]  RESET_CFG   = 6'b100010
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  adc_spi_responder_if.slave   spi,
  output logic [2:0]           sample_ch,
  input  logic [11:0]          sample_data,
  output logic                 conv_busy,
  output logic                 frame_done,
  output logic                 proto_err,
  input  logic                 err_clr
);

  localparam int              CW        = $clog2(CONV_CYCLES + 1);
  localparam logic [CW-1:0]   CONV_LAST = CW'(CONV_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CONV  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Input synchronizers; edge detection only ever looks at the last stage.
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, din_sync;
  logic                   sclk_prev, cs_prev;
  logic                   sclk_s, cs_s, din_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign din_s     = din_sync[SYNC_STAGES-1];
  assign sclk_rise =  sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s &  sclk_prev;
  assign cs_rise   =  cs_s   & ~cs_prev;
  assign cs_fall   = ~cs_s   &  cs_prev;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      din_sync  <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.adc_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0],   spi.adc_cs_n};
      din_sync  <= {din_sync[SYNC_STAGES-2:0],  spi.adc_din};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
    end
  end

  // Datapath state
  logic [5:0]    cfg, cfg_sh;
  logic [11:0]   result, dout_sh;
  logic [3:0]    bit_cnt;
  logic [CW-1:0] conv_cnt;
  logic          dout_q;

  // FSM control strobes
  logic start_frame, cap_bit, shift_bit, end_frame, conv_err, conv_done;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    cap_bit     = 1'b0;
    shift_bit   = 1'b0;
    end_frame   = 1'b0;
    conv_err    = 1'b0;
    conv_done   = 1'b0;
    conv_busy   = 1'b0;
    case (state)
      IDLE: begin
        // A frame whose cs_n fell during CONV never produces a fall here,
        // so it is ignored until cs_n goes high again.
        if (cs_fall) begin
          start_frame = 1'b1;
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          end_frame = 1'b1;
          state_nxt = CONV;
        end else begin
          cap_bit   = sclk_rise;
          shift_bit = sclk_fall;
        end
      end
      CONV: begin
        conv_busy = 1'b1;
        conv_err  = cs_fall;
        if (conv_cnt == CONV_LAST) begin
          conv_done = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cfg        <= RESET_CFG;
      cfg_sh     <= RESET_CFG;
      result     <= 12'h000;
      dout_sh    <= 12'h000;
      bit_cnt    <= 4'd0;
      conv_cnt   <= '0;
      dout_q     <= 1'b0;
      sample_ch  <= 3'd0;
      frame_done <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      frame_done <= end_frame && (bit_cnt >= 4'd12);

      if (start_frame) begin
        bit_cnt <= 4'd0;
        dout_q  <= result[11];
        dout_sh <= {result[10:0], 1'b0};
      end

      if (cap_bit) begin
        if (bit_cnt < 4'd6) begin
          cfg_sh <= {cfg_sh[4:0], din_s};
        end
        if (bit_cnt != 4'd15) begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end

      // Zeros shift in behind the result, so DOUT reads 0 past bit 12.
      if (shift_bit) begin
        dout_q  <= dout_sh[11];
        dout_sh <= {dout_sh[10:0], 1'b0};
      end

      if (end_frame) begin
        dout_q   <= 1'b0;
        conv_cnt <= '0;
        if (bit_cnt >= 4'd6) begin
          cfg       <= cfg_sh;
          sample_ch <= {cfg_sh[3], cfg_sh[2], cfg_sh[4]};
        end
      end

      if (conv_busy) begin
        conv_cnt <= conv_cnt + 1'b1;
      end

      // Bipolar mode offsets to two's complement by flipping the MSB.
      if (conv_done) begin
        result <= cfg[1] ? sample_data : (sample_data ^ 12'h800);
      end

      if ((end_frame && (bit_cnt < 4'd6)) || conv_err) begin
        proto_err <= 1'b1;
      end else if (err_clr) begin
        proto_err <= 1'b0;
      end
    end
  end

  assign spi.adc_dout = dout_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
module tb_adc_spi_responder;

  localparam int         CONV_CYCLES = 80;
  localparam logic [5:0] RESET_CFG   = 6'b100010;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic [2:0]  sample_ch;
  logic [11:0] sample_data;
  logic        conv_busy, frame_done, proto_err, err_clr;

  adc_spi_responder_if spi ();

  adc_spi_responder #(
    .CONV_CYCLES (CONV_CYCLES),
    .SYNC_STAGES (2),
    .RESET_CFG   (RESET_CFG)
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .spi           (spi.slave),
    .sample_ch     (sample_ch),
    .sample_data   (sample_data),
    .conv_busy     (conv_busy),
    .frame_done    (frame_done),
    .proto_err     (proto_err),
    .err_clr       (err_clr)
  );

  always #5 clk_clk = ~clk_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int fd_cnt   = 0;
  int busy_cnt = 0;

  always @(negedge clk_clk) begin
    if (frame_done === 1'b1) fd_cnt = fd_cnt + 1;
    if (conv_busy === 1'b1) busy_cnt = busy_cnt + 1;
  end

  // Reference model: what the converter holds, in specification terms.
  logic [5:0]  m_cfg;
  logic [11:0] m_result;
  logic [2:0]  m_ch;
  logic        m_err;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_clk);
  endtask

  // Master side: sclk = clk/8, DIN changes on sclk fall, DOUT sampled at sclk rise.
  task automatic clock_bits(input logic [5:0] cfg, input int n, input int abort_at,
                            output logic [15:0] rd);
    rd = '0;
    spi.adc_cs_n = 1'b0;
    spi.adc_din  = cfg[5];
    wait_clk(4);
    for (int i = 0; i < n; i++) begin
      rd = {rd[14:0], spi.adc_dout};
      spi.adc_sclk = 1'b1;
      if (i == abort_at) begin
        wait_clk(2);
        reset_reset_n = 1'b0;
        wait_clk(2);
        return;
      end
      wait_clk(4);
      spi.adc_sclk = 1'b0;
      if (i < 5) spi.adc_din = cfg[4-i];
      else       spi.adc_din = 1'b0;
      wait_clk(4);
    end
    spi.adc_cs_n = 1'b1;
    spi.adc_din  = 1'b0;
  endtask

  task automatic do_frame(input logic [5:0] cfg, input int n, input int post_wait);
    logic [15:0] rd, exp;
    int fd0, b0;
    fd0 = fd_cnt;
    b0  = busy_cnt;
    if (n >= 12) exp = 16'(m_result) << (n - 12);
    else         exp = 16'(m_result) >> (12 - n);
    clock_bits(cfg, n, -1, rd);
    if (n >= 6) begin
      m_cfg = cfg;
      m_ch  = {cfg[3], cfg[2], cfg[4]};
    end else begin
      m_err = 1'b1;
    end
    m_result = m_cfg[1] ? sample_data : (sample_data ^ 12'h800);
    wait_clk(post_wait);
    chk("dout_word", rd, exp);
    if (post_wait >= 88) begin
      chk("frame_done_pulses", 16'(fd_cnt - fd0), (n >= 12) ? 16'd1 : 16'd0);
      chk("conv_busy_cycles", 16'(busy_cnt - b0), 16'(CONV_CYCLES));
      chk("sample_ch", 16'(sample_ch), 16'(m_ch));
      chk("proto_err", 16'(proto_err), 16'(m_err));
    end
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    wait_clk(1);
    err_clr = 1'b0;
    wait_clk(1);
    m_err = 1'b0;
    chk("proto_err_cleared", 16'(proto_err), 16'd0);
  endtask

  initial begin
    logic [15:0] rd;
    int fd0, b0;

    spi.adc_sclk = 1'b0;
    spi.adc_cs_n = 1'b1;
    spi.adc_din  = 1'b0;
    err_clr      = 1'b0;
    sample_data  = 12'h000;
    wait_clk(5);
    chk("rst_dout", 16'(spi.adc_dout), 16'd0);
    chk("rst_sample_ch", 16'(sample_ch), 16'd0);
    chk("rst_conv_busy", 16'(conv_busy), 16'd0);
    chk("rst_frame_done", 16'(frame_done), 16'd0);
    chk("rst_proto_err", 16'(proto_err), 16'd0);
    reset_reset_n = 1'b1;
    wait_clk(5);
    m_cfg = RESET_CFG; m_result = 12'h000; m_ch = 3'd0; m_err = 1'b0;

    // ch1 unipolar; first frame returns 000
    sample_data = 12'hABC;
    do_frame(6'b110011, 12, 100);
    // ch5 bipolar reads ABC, then unipolar reads 123^800
    sample_data = 12'h123;
    do_frame(6'b111000, 12, 100);
    do_frame(6'b111010, 12, 100);
    // short 4-edge frame: error, cfg kept
    sample_data = 12'h456;
    do_frame(6'b000101, 4, 100);
    pulse_err_clr();
    // 16-edge frame: trailing bits are zero
    sample_data = 12'h789;
    do_frame(6'b100110, 16, 100);

    // cs_n falls early in the conversion window
    sample_data = 12'h0FF;
    fd0 = fd_cnt;
    b0  = busy_cnt;
    do_frame(6'b011100, 12, 13);
    clock_bits(6'b101010, 12, -1, rd);
    m_err = 1'b1;
    wait_clk(100);
    chk("overlap_dout_zero", rd, 16'd0);
    chk("overlap_busy_cycles", 16'(busy_cnt - b0), 16'(CONV_CYCLES));
    chk("overlap_frame_done", 16'(fd_cnt - fd0), 16'd1);
    chk("overlap_proto_err", 16'(proto_err), 16'(m_err));
    chk("overlap_sample_ch", 16'(sample_ch), 16'(m_ch));
    pulse_err_clr();

    // back-to-back random frames
    for (int k = 0; k < 10; k++) begin
      sample_data = 12'($urandom);
      do_frame(6'($urandom), int'($urandom_range(16, 3)), 90);
    end
    pulse_err_clr();

    // reset during bit 7 of a frame
    sample_data = 12'hF0F;
    clock_bits(6'b111111, 12, 6, rd);
    chk("midrst_dout", 16'(spi.adc_dout), 16'd0);
    chk("midrst_conv_busy", 16'(conv_busy), 16'd0);
    chk("midrst_sample_ch", 16'(sample_ch), 16'd0);
    chk("midrst_proto_err", 16'(proto_err), 16'd0);
    spi.adc_sclk = 1'b0;
    spi.adc_cs_n = 1'b1;
    spi.adc_din  = 1'b0;
    wait_clk(2);
    reset_reset_n = 1'b1;
    wait_clk(5);
    m_cfg = RESET_CFG; m_result = 12'h000; m_ch = 3'd0; m_err = 1'b0;
    // short frame keeps reset cfg (unipolar), so the raw sample comes back next
    do_frame(6'b000000, 4, 100);
    do_frame(6'b110011, 12, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
